// File: rtl/fpu_issue.sv
// Requester-side FPU controller: accepts one op, holds operands for the FPU, waits for the
// ready pulse (with a watchdog), then presents the tagged result or an error code.
module fpu_issue #(
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned MAX_CTL = 20
) (
  input  logic             clk,
  input  logic             rstn,
  // Request port
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_ctl,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  input  logic [TAG_W-1:0] req_tag,
  // FPU side
  output logic [4:0]       fpu_ctl,
  output logic [31:0]      fpu_x1,
  output logic [31:0]      fpu_x2,
  output logic             fpu_en,
  input  logic             fpu_ready,
  input  logic [31:0]      fpu_y,
  // Result port
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_y,
  output logic [TAG_W-1:0] res_tag,
  output logic [1:0]       res_err
);

  localparam int unsigned    WdW    = $clog2(TIMEOUT);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
  localparam logic [WdW-1:0] WdMax  = '1;
  localparam logic [4:0]     CtlMax = 5'(MAX_CTL);

  localparam logic [1:0] ErrOk      = 2'd0;
  localparam logic [1:0] ErrIllegal = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e         state_q, state_d;
  logic [WdW-1:0] wd_q;

  logic accept;
  logic illegal;
  logic capture;
  logic expire;
  logic wd_clr;
  logic wd_inc;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    fpu_en    = 1'b0;
    res_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    wd_clr    = 1'b0;
    wd_inc    = 1'b0;
    illegal   = (req_ctl > CtlMax);

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = illegal ? StDone : StIssue;
        end
      end
      // fpu_ready is deliberately ignored here: it may still be the previous op's pulse.
      StIssue: begin
        fpu_en  = 1'b1;
        wd_clr  = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (fpu_ready) begin
          capture = 1'b1;
          state_d = StDone;
        end else if (wd_q == WdLast) begin
          expire  = 1'b1;
          state_d = StDone;
        end else begin
          wd_inc = 1'b1;
        end
      end
      StDone: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Operands only load on accept so ctl stays stable until the FPU completes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fpu_ctl <= '0;
      fpu_x1  <= '0;
      fpu_x2  <= '0;
      res_tag <= '0;
      res_y   <= '0;
      res_err <= ErrOk;
    end else begin
      if (accept) begin
        fpu_ctl <= req_ctl;
        fpu_x1  <= req_x1;
        fpu_x2  <= req_x2;
        res_tag <= req_tag;
        if (illegal) begin
          res_y   <= '0;
          res_err <= ErrIllegal;
        end
      end
      if (capture) begin
        res_y   <= fpu_y;
        res_err <= ErrOk;
      end
      if (expire) begin
        res_y   <= '0;
        res_err <= ErrTimeout;
      end
    end
  end

  // Watchdog saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wd_q <= '0;
    end else if (wd_clr) begin
      wd_q <= '0;
    end else if (wd_inc && (wd_q != WdMax)) begin
      wd_q <= wd_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
// Self-checking bench for fpu_issue: behavioural FPU with per-opcode latency, directed
// scenarios and randomized ops checked against latency/result rules.
module tb_fpu_issue;

  localparam int unsigned TAG_W   = 5;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned MAX_CTL = 20;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [4:0]       req_ctl = '0;
  logic [31:0]      req_x1 = '0;
  logic [31:0]      req_x2 = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [4:0]       fpu_ctl;
  logic [31:0]      fpu_x1;
  logic [31:0]      fpu_x2;
  logic             fpu_en;
  logic             fpu_ready;
  logic [31:0]      fpu_y;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [31:0]      res_y;
  logic [TAG_W-1:0] res_tag;
  logic [1:0]       res_err;

  logic        model_ready = 1'b0;
  logic [31:0] model_y = '0;
  logic        stray_ready = 1'b0;
  logic [31:0] stray_y = '0;
  bit          fpu_hang = 1'b0;

  int checks = 0;
  int errors = 0;

  // do_op results
  bit               o_rdy, o_hold, o_bp, o_rel;
  int               o_vcyc, o_en, o_encyc;
  logic [31:0]      o_y;
  logic [TAG_W-1:0] o_tag;
  logic [1:0]       o_err;

  assign fpu_ready = model_ready | stray_ready;
  assign fpu_y     = stray_ready ? stray_y : model_y;

  fpu_issue #(
    .TAG_W  (TAG_W),
    .TIMEOUT(TIMEOUT),
    .MAX_CTL(MAX_CTL)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_ctl  (req_ctl),
    .req_x1   (req_x1),
    .req_x2   (req_x2),
    .req_tag  (req_tag),
    .fpu_ctl  (fpu_ctl),
    .fpu_x1   (fpu_x1),
    .fpu_x2   (fpu_x2),
    .fpu_en   (fpu_en),
    .fpu_ready(fpu_ready),
    .fpu_y    (fpu_y),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_y    (res_y),
    .res_tag  (res_tag),
    .res_err  (res_err)
  );

  always #5 clk = ~clk;

  // FPU stage count per opcode.
  function automatic int lat(input logic [4:0] c);
    case (c)
      5'd0, 5'd1:  return 1;  // fadd, fsub
      5'd2:        return 2;  // fmul
      5'd3:        return 3;  // finv
      5'd4:        return 6;  // fdiv
      5'd5:        return 5;  // sqrt
      5'd6, 5'd7:  return 2;  // ftoi, itof
      5'd8:        return 1;  // floor
      5'd20:       return 2;  // fsqr
      default:     return 0;
    endcase
  endfunction

  function automatic logic [31:0] fpu_func(input logic [4:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
    if (c == 5'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (c == 5'd4 && a == 32'h4120_0000 && b == 32'h4000_0000) return 32'h40A0_0000;
    if (c == 5'd11) return a & 32'h7FFF_FFFF;
    if (c >= 5'd14 && c <= 5'd16) return {31'd0, a < b};
    return a ^ {b[15:0], b[31:16]} ^ {27'd0, c};
  endfunction

  // FPU: ready arrives in cycle 2+N counting the accept edge as 0.
  initial begin : fpu_model
    logic [4:0]  c;
    logic [31:0] a, b;
    forever begin
      @(negedge clk);
      if (fpu_en === 1'b1 && !fpu_hang) begin
        c = fpu_ctl;
        a = fpu_x1;
        b = fpu_x2;
        @(posedge clk);
        repeat (lat(c)) @(posedge clk);
        #1;
        model_y     = fpu_func(c, a, b);
        model_ready = 1'b1;
        @(posedge clk);
        #1 model_ready = 1'b0;
      end
    end
  end

  initial begin : global_guard
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "bench time limit");
  end

  task automatic do_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] t, input int hold, input bit scramble);
    @(negedge clk);
    o_rdy     = req_ready;
    req_valid = 1'b1;
    req_ctl   = c;
    req_x1    = a;
    req_x2    = b;
    req_tag   = t;
    @(posedge clk);
    o_vcyc = -1; o_en = 0; o_encyc = -1;
    o_hold = 1'b1; o_bp = 1'b1; o_rel = 1'b0;
    o_y = '0; o_tag = '0; o_err = '0;
    for (int k = 1; k <= 40 && o_vcyc < 0; k++) begin
      @(negedge clk);
      if (fpu_en === 1'b1) begin
        o_en++;
        o_encyc = k;
      end
      if (fpu_ctl !== c || fpu_x1 !== a || fpu_x2 !== b) o_hold = 1'b0;
      if (res_valid === 1'b1) begin
        o_vcyc    = k;
        req_valid = 1'b0;
      end else if (scramble) begin
        req_valid = 1'($urandom_range(0, 1));
        req_ctl   = 5'($urandom);
        req_x1    = $urandom;
        req_x2    = $urandom;
        req_tag   = TAG_W'($urandom);
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    if (o_vcyc < 0) return;
    o_y   = res_y;
    o_tag = res_tag;
    o_err = res_err;
    repeat (hold) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_y !== o_y || res_tag !== o_tag ||
          res_err !== o_err) o_bp = 1'b0;
    end
    res_ready = 1'b1;
    @(negedge clk);
    o_rel     = (res_valid === 1'b0 && req_ready === 1'b1);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({fpu_en, res_valid, fpu_ctl, fpu_x1, fpu_x2, res_y, res_tag, res_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b v=%b ctl=%h x1=%h x2=%h y=%h tag=%h err=%h want all 0",
               fpu_en, res_valid, fpu_ctl, fpu_x1, fpu_x2, res_y, res_tag, res_err);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got rdy=%b v=%b want rdy=1 v=0", req_ready, res_valid);
    end
  endtask

  task automatic test_fadd();
    do_op(5'd0, 32'h3F80_0000, 32'h4000_0000, 5'd3, 0, 1'b0);
    checks++;
    if (o_rdy !== 1'b1) begin errors++; $display("FAIL fadd_req_ready got %b want 1", o_rdy); end
    checks++;
    if (o_en !== 1 || o_encyc !== 1) begin
      errors++; $display("FAIL fadd_en got count=%0d cycle=%0d want 1/1", o_en, o_encyc);
    end
    checks++;
    if (o_vcyc !== 4) begin errors++; $display("FAIL fadd_vcyc got %0d want 4", o_vcyc); end
    checks++;
    if (o_y !== 32'h4040_0000 || o_tag !== 5'd3 || o_err !== 2'd0) begin
      errors++;
      $display("FAIL fadd_res got y=%h tag=%0d err=%0d want 40400000/3/0", o_y, o_tag, o_err);
    end
    checks++;
    if (o_rel !== 1'b1) begin errors++; $display("FAIL fadd_release got %b want 1", o_rel); end
  endtask

  task automatic test_fabs();
    logic [TAG_W-1:0] t;
    t = TAG_W'($urandom);
    do_op(5'd11, 32'hC0A0_0000, $urandom, t, 0, 1'b0);
    checks++;
    if (o_vcyc !== 3) begin errors++; $display("FAIL fabs_vcyc got %0d want 3", o_vcyc); end
    checks++;
    if (o_y !== 32'h40A0_0000 || o_tag !== t || o_err !== 2'd0) begin
      errors++;
      $display("FAIL fabs_res got y=%h tag=%0d err=%0d want 40a00000/%0d/0", o_y, o_tag, o_err, t);
    end
  endtask

  task automatic test_fdiv_hold();
    do_op(5'd4, 32'h4120_0000, 32'h4000_0000, 5'd17, 0, 1'b1);
    checks++;
    if (o_vcyc !== 9) begin errors++; $display("FAIL fdiv_vcyc got %0d want 9", o_vcyc); end
    checks++;
    if (o_hold !== 1'b1) begin errors++; $display("FAIL fdiv_operand_hold got %b want 1", o_hold); end
    checks++;
    if (o_y !== 32'h40A0_0000 || o_tag !== 5'd17) begin
      errors++; $display("FAIL fdiv_res got y=%h tag=%0d want 40a00000/17", o_y, o_tag);
    end
  endtask

  task automatic test_illegal();
    do_op(5'd25, $urandom, $urandom, 5'd9, 0, 1'b0);
    checks++;
    if (o_en !== 0) begin errors++; $display("FAIL illegal_en got %0d want 0", o_en); end
    checks++;
    if (o_vcyc !== 1) begin errors++; $display("FAIL illegal_vcyc got %0d want 1", o_vcyc); end
    checks++;
    if (o_err !== 2'd1 || o_y !== 32'd0 || o_tag !== 5'd9) begin
      errors++; $display("FAIL illegal_res got err=%0d y=%h tag=%0d want 1/0/9", o_err, o_y, o_tag);
    end
  endtask

  task automatic test_timeout();
    fpu_hang = 1'b1;
    do_op(5'd1, $urandom, $urandom, 5'd21, 0, 1'b0);
    fpu_hang = 1'b0;
    checks++;
    if (o_vcyc !== 2 + int'(TIMEOUT)) begin
      errors++; $display("FAIL timeout_vcyc got %0d want %0d", o_vcyc, 2 + TIMEOUT);
    end
    checks++;
    if (o_err !== 2'd2 || o_y !== 32'd0 || o_en !== 1) begin
      errors++; $display("FAIL timeout_res got err=%0d y=%h en=%0d want 2/0/1", o_err, o_y, o_en);
    end
    // A stray ready pulse in IDLE must be ignored.
    @(negedge clk);
    stray_y     = $urandom | 32'h1;
    stray_ready = 1'b1;
    @(negedge clk);
    stray_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || res_y !== 32'd0 || res_err !== 2'd2 ||
        res_tag !== 5'd21) begin
      errors++;
      $display("FAIL late_ready got rdy=%b v=%b y=%h err=%0d tag=%0d want 1/0/0/2/21",
               req_ready, res_valid, res_y, res_err, res_tag);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    do_op(5'd2, a, b, 5'd30, 5, 1'b0);
    checks++;
    if (o_vcyc !== 5) begin errors++; $display("FAIL bp_vcyc got %0d want 5", o_vcyc); end
    checks++;
    if (o_bp !== 1'b1) begin errors++; $display("FAIL bp_stable got %b want 1", o_bp); end
    checks++;
    if (o_y !== fpu_func(5'd2, a, b) || o_rel !== 1'b1) begin
      errors++;
      $display("FAIL bp_res got y=%h rel=%b want %h/1", o_y, o_rel, fpu_func(5'd2, a, b));
    end
  endtask

  task automatic test_back_to_back();
    logic [TAG_W-1:0] prev;
    @(negedge clk);
    res_ready = 1'b1;
    req_valid = 1'b1;
    req_ctl   = 5'd31;
    req_tag   = TAG_W'($urandom);
    prev      = req_tag;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'(k % 2 == 0) || res_valid !== 1'(k % 2 == 1)) begin
        errors++;
        $display("FAIL b2b_handshake cycle %0d got rdy=%b v=%b want rdy=%0d v=%0d",
                 k, req_ready, res_valid, k % 2 == 0, k % 2 == 1);
      end
      if (k % 2 == 1) begin
        checks++;
        if (res_tag !== prev || res_err !== 2'd1) begin
          errors++;
          $display("FAIL b2b_tag cycle %0d got tag=%0d err=%0d want %0d/1", k, res_tag, res_err, prev);
        end
      end
      req_ctl = 5'($urandom_range(21, 31));
      req_tag = TAG_W'($urandom);
      prev    = req_tag;
    end
    req_valid = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    req_valid = 1'b1;
    req_ctl   = 5'd4;
    req_x1    = $urandom;
    req_x2    = $urandom;
    req_tag   = 5'd12;
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checks++;
    if ({fpu_en, res_valid, fpu_ctl, fpu_x1, fpu_x2, res_y, res_tag, res_err} !== '0 ||
        req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_wait got en=%b v=%b ctl=%h y=%h tag=%h err=%h rdy=%b want 0s rdy=1",
               fpu_en, res_valid, fpu_ctl, res_y, res_tag, res_err, req_ready);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || res_y !== 32'd0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_abandon got v=%b y=%h rdy=%b want 0/0/1", res_valid, res_y, req_ready);
    end
  endtask

  task automatic test_random();
    logic [4:0]       c;
    logic [31:0]      a, b, ey;
    logic [TAG_W-1:0] t;
    bit               legal;
    int               ecyc;
    for (int i = 0; i < 24; i++) begin
      legal = ($urandom_range(0, 5) != 0);
      c     = legal ? 5'($urandom_range(0, MAX_CTL)) : 5'($urandom_range(MAX_CTL + 1, 31));
      a     = $urandom;
      b     = $urandom;
      t     = TAG_W'($urandom);
      ey    = legal ? fpu_func(c, a, b) : 32'd0;
      ecyc  = legal ? 3 + lat(c) : 1;
      do_op(c, a, b, t, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      checks++;
      if (o_vcyc !== ecyc) begin
        errors++; $display("FAIL rand_vcyc op %0d ctl %0d got %0d want %0d", i, c, o_vcyc, ecyc);
      end
      checks++;
      if (o_y !== ey || o_tag !== t || o_err !== (legal ? 2'd0 : 2'd1)) begin
        errors++;
        $display("FAIL rand_res op %0d ctl %0d got y=%h tag=%0d err=%0d want %h/%0d/%0d",
                 i, c, o_y, o_tag, o_err, ey, t, legal ? 0 : 1);
      end
      checks++;
      if (o_en !== (legal ? 1 : 0) || o_hold !== 1'b1 || o_bp !== 1'b1 || o_rel !== 1'b1) begin
        errors++;
        $display("FAIL rand_proto op %0d got en=%0d hold=%b bp=%b rel=%b want %0d/1/1/1",
                 i, o_en, o_hold, o_bp, o_rel, legal ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_fabs();
    test_fdiv_hold();
    test_illegal();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
